// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : cdc_handshake_tx
// Description : Source side of a 4-phase req/ack CDC transfer. Holds one word
//               on data_out, raises req, and waits for synchronized ack to
//               complete the full return-to-zero cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic                  req,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_async,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_HIGH = 2'd1,
    ST_REQ_LOW  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    w_ack_sync;
  logic                    r_req;
  logic                    w_req_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    w_load;
  logic                    r_done;
  logic                    w_done_next;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_CNT_W-1:0]      w_cnt_next;
  logic                    r_timeout;
  logic                    w_timeout_hit;

  assign w_ack_sync  = r_sync[SYNC_STAGES-1];
  assign src_ready   = (r_state == ST_IDLE);
  assign req         = r_req;
  assign data_out    = r_data;
  assign done        = r_done;
  assign timeout_err = r_timeout;

  always_comb begin
    w_state_next  = r_state;
    w_req_next    = r_req;
    w_load        = 1'b0;
    w_done_next   = 1'b0;
    w_cnt_next    = r_cnt;
    w_timeout_hit = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (src_valid) begin
          w_state_next = ST_REQ_HIGH;
          w_req_next   = 1'b1;
          w_load       = 1'b1;
        end
      end
      ST_REQ_HIGH: begin
        if (w_ack_sync) begin
          w_state_next = ST_REQ_LOW;
          w_req_next   = 1'b0;
        end
      end
      ST_REQ_LOW: begin
        if (!w_ack_sync) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_req_next   = 1'b0;
      end
    endcase

    // Count cycles spent waiting in one state; saturate at the limit.
    if ((w_state_next != r_state) || (r_state == ST_IDLE)) begin
      w_cnt_next = '0;
    end else if (r_cnt != c_TIMEOUT) begin
      w_cnt_next = r_cnt + 1'b1;
    end

    if ((TIMEOUT_CYCLES != 0) && (w_cnt_next == c_TIMEOUT)) begin
      w_timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_sync    <= '0;
      r_req     <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ack_async};
      r_req   <= w_req_next;
      r_done  <= w_done_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_data <= src_data;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_handshake_tx
// Description : Self-checking bench for cdc_handshake_tx: directed scenarios
//               with literal expectations plus randomized traffic against a
//               cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int TO   = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          src_valid;
  logic [DW-1:0] src_data;
  logic          src_ready;
  logic          req;
  logic [DW-1:0] data_out;
  logic          ack_async;
  logic          done;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  cdc_handshake_tx #(
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .req        (req),
    .data_out   (data_out),
    .ack_async  (ack_async),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0 idle, 1 waiting for ack high, 2 waiting for ack low.
  // Ack is seen by the control logic SYNC edges after it is sampled.
  int            m_phase;
  int            m_wait;
  logic          m_req, m_done, m_err;
  logic [DW-1:0] m_data;
  logic [SYNC-1:0] m_hist;
  bit            m_valid = 1'b0;

  always @(posedge CLK) begin
    int   ph;
    logic ack_seen;
    if (RST) begin
      m_phase <= 0;
      m_wait  <= 0;
      m_req   <= 1'b0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_data  <= '0;
      m_hist  <= '0;
      m_valid <= 1'b1;
    end else begin
      ack_seen = m_hist[SYNC-1];
      ph       = m_phase;
      m_done  <= 1'b0;
      if (ph == 0 && src_valid) begin
        m_data <= src_data;
        m_req  <= 1'b1;
        ph     = 1;
      end else if (ph == 1 && ack_seen) begin
        m_req <= 1'b0;
        ph    = 2;
      end else if (ph == 2 && !ack_seen) begin
        m_done <= 1'b1;
        ph     = 0;
      end
      if (ph != m_phase || ph == 0) begin
        m_wait <= 0;
      end else begin
        m_wait <= m_wait + 1;
        if (TO != 0 && m_wait + 1 >= TO) m_err <= 1'b1;
      end
      m_phase <= ph;
      m_hist  <= {m_hist[SYNC-2:0], ack_async};
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      checks++;
      if ({req, done, timeout_err, src_ready, data_out} !==
          {m_req, m_done, m_err, (m_phase == 0), m_data}) begin
        failures++;
        $display("FAIL model t=%0t req/done/err/rdy/data got %b%b%b%b/%02h want %b%b%b%b/%02h",
                 $time, req, done, timeout_err, src_ready, data_out,
                 m_req, m_done, m_err, (m_phase == 0), m_data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input logic v, input int budget);
    int n = 0;
    while (req !== v && n < budget) begin
      tick();
      n++;
    end
    chk("wait_req", int'(req), int'(v));
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done", int'(done), 1);
  endtask

  task automatic handshake();
    ack_async = 1'b1;
    wait_req(1'b0, 10);
    ack_async = 1'b0;
    wait_done(10);
  endtask

  initial begin
    RST       = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    ack_async = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_req", int'(req), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(timeout_err), 0);
    chk("rst_ready", int'(src_ready), 1);

    // Single transfer with edge-exact latencies
    src_valid = 1'b1;
    src_data  = 8'hA5;
    tick();
    chk("t2_req_up", int'(req), 1);
    chk("t2_data", int'(data_out), 'hA5);
    chk("t2_busy", int'(src_ready), 0);
    src_valid = 1'b0;
    repeat (4) tick();
    ack_async = 1'b1;
    tick();
    tick();
    chk("t2_req_e7", int'(req), 1);
    tick();
    chk("t2_req_e8", int'(req), 0);
    tick();
    tick();
    ack_async = 1'b0;
    tick();
    tick();
    chk("t2_done_e12", int'(done), 0);
    tick();
    chk("t2_done_e13", int'(done), 1);
    chk("t2_ready_e13", int'(src_ready), 1);
    tick();
    chk("t2_done_e14", int'(done), 0);
    chk("t2_err", int'(timeout_err), 0);

    // Back-to-back with src_valid held
    src_valid = 1'b1;
    src_data  = 8'h11;
    tick();
    chk("t3_req", int'(req), 1);
    chk("t3_data1", int'(data_out), 'h11);
    src_data = 8'h22;
    tick();
    tick();
    chk("t3_hold_a", int'(data_out), 'h11);
    ack_async = 1'b1;
    wait_req(1'b0, 10);
    chk("t3_hold_b", int'(data_out), 'h11);
    ack_async = 1'b0;
    wait_done(10);
    chk("t3_hold_c", int'(data_out), 'h11);
    chk("t3_ready", int'(src_ready), 1);
    tick();
    chk("t3_next_req", int'(req), 1);
    chk("t3_data2", int'(data_out), 'h22);
    src_valid = 1'b0;
    handshake();

    // Busy ignore
    src_valid = 1'b1;
    src_data  = 8'h33;
    tick();
    src_valid = 1'b0;
    src_data  = 8'h44;
    tick();
    src_valid = 1'b1;
    src_data  = 8'h55;
    tick();
    src_valid = 1'b0;
    chk("t4_data", int'(data_out), 'h33);
    handshake();
    tick();
    tick();
    chk("t4_no_extra", int'(req), 0);
    chk("t4_data_kept", int'(data_out), 'h33);

    // Timeout with no ack
    src_valid = 1'b1;
    src_data  = 8'h66;
    tick();
    src_valid = 1'b0;
    repeat (7) tick();
    chk("t5_err_pre", int'(timeout_err), 0);
    tick();
    chk("t5_err", int'(timeout_err), 1);
    chk("t5_req", int'(req), 1);
    handshake();
    chk("t5_err_sticky", int'(timeout_err), 1);

    // Reset while waiting for ack to drop
    tick();
    src_valid = 1'b1;
    src_data  = 8'h77;
    tick();
    src_valid = 1'b0;
    ack_async = 1'b1;
    wait_req(1'b0, 10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ack_async = 1'b0;
    chk("t6_req", int'(req), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_ready", int'(src_ready), 1);
    chk("t6_err", int'(timeout_err), 0);
    repeat (3) tick();
    src_valid = 1'b1;
    src_data  = 8'h88;
    tick();
    src_valid = 1'b0;
    chk("t6_req2", int'(req), 1);
    chk("t6_data2", int'(data_out), 'h88);
    handshake();

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      src_valid = 1'($urandom_range(0, 1));
      src_data  = DW'($urandom);
      if ($urandom_range(0, 1) == 0) ack_async = req;
      if ($urandom_range(0, 49) == 0) ack_async = ~ack_async;
      RST = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST       = 1'b0;
    src_valid = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
